uart_tx_frame: RTL and testbench

UART transmitter that serialises one parallel byte per frame onto a single line, the transmit counterpart of the UART RX path. It runs on the same oversampled clock as the RX bit/edge counters and holds each serial bit for `prescale` clock cycles, so TX and RX share one baud configuration. Frame format: start bit, 8 data bits LSB first, optional parity bit, stop bit(s).

---
 rtl/uart_tx_frame_if.sv | 22 ++
 rtl/uart_tx_frame.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_frame.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// Parallel-side handshake bundle of the UART transmitter: byte, request, frame
// configuration and the busy indication returned by the transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic [5:0]            prescale;
  logic                  busy;

  modport master (
    output p_data, data_valid, par_en, par_typ, prescale,
    input  busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ, prescale,
    output busy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity,
// stop bit(s), each held for prescale clocks. UART_TX_STOP2_EN selects two stop bits.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_frame_if.slave   tx_if,
  output logic             tx_out
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
`ifdef UART_TX_STOP2_EN
  localparam logic STOP_LAST = 1'b1;
`else
  localparam logic STOP_LAST = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [5:0]            cnt_r, cnt_nxt_s;
  logic [BW-1:0]         bit_idx_r, bit_nxt_s;
  logic                  stop_cnt_r, stop_nxt_s;
  logic                  tx_r, tx_nxt_s;
  logic                  busy_r;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  par_en_r;
  logic                  par_typ_r;
  logic [5:0]            pre_r;
  logic [5:0]            pm1_s;
  logic                  last_s;

  function automatic logic parity_f(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // A prescale of 0 behaves as 1, so the terminal edge count is never below 0.
  assign pm1_s  = (pre_r == 6'd0) ? 6'd0 : (pre_r - 6'd1);
  assign last_s = (cnt_r == pm1_s);

  // Next-state, counters and next line level, all derived from registered state.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    bit_nxt_s   = bit_idx_r;
    stop_nxt_s  = stop_cnt_r;
    tx_nxt_s    = tx_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        tx_nxt_s  = 1'b1;
        cnt_nxt_s = 6'd0;
        if (tx_if.data_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = START;
          tx_nxt_s    = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        tx_nxt_s = 1'b0;
        if (last_s) begin
          cnt_nxt_s   = 6'd0;
          bit_nxt_s   = {BW{1'b0}};
          state_nxt_s = DATA;
          tx_nxt_s    = data_r[0];
        end else begin
          cnt_nxt_s = cnt_r + 6'd1;
        end
      end
      DATA: begin
        tx_nxt_s = data_r[bit_idx_r];
        if (last_s) begin
          cnt_nxt_s = 6'd0;
          if (bit_idx_r == BIT_LAST) begin
            bit_nxt_s = {BW{1'b0}};
            if (par_en_r) begin
              state_nxt_s = PARITY;
              tx_nxt_s    = parity_f(data_r, par_typ_r);
            end else begin
              state_nxt_s = STOP;
              stop_nxt_s  = 1'b0;
              tx_nxt_s    = 1'b1;
            end
          end else begin
            bit_nxt_s = bit_idx_r + BIT_ONE;
            tx_nxt_s  = data_r[bit_idx_r + BIT_ONE];
          end
        end else begin
          cnt_nxt_s = cnt_r + 6'd1;
        end
      end
      PARITY: begin
        tx_nxt_s = parity_f(data_r, par_typ_r);
        if (last_s) begin
          cnt_nxt_s   = 6'd0;
          state_nxt_s = STOP;
          stop_nxt_s  = 1'b0;
          tx_nxt_s    = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + 6'd1;
        end
      end
      STOP: begin
        tx_nxt_s = 1'b1;
        if (last_s) begin
          cnt_nxt_s = 6'd0;
          if (stop_cnt_r == STOP_LAST) begin
            state_nxt_s = IDLE;
            stop_nxt_s  = 1'b0;
          end else begin
            stop_nxt_s = 1'b1;
          end
        end else begin
          cnt_nxt_s = cnt_r + 6'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 6'd0;
        bit_nxt_s   = {BW{1'b0}};
        stop_nxt_s  = 1'b0;
        tx_nxt_s    = 1'b1;
      end
    endcase
  end

  // State, counters, registered outputs and the frame snapshot taken on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 6'd0;
      bit_idx_r  <= {BW{1'b0}};
      stop_cnt_r <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      data_r     <= {DATA_WIDTH{1'b0}};
      par_en_r   <= 1'b0;
      par_typ_r  <= 1'b0;
      pre_r      <= 6'd0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      bit_idx_r  <= bit_nxt_s;
      stop_cnt_r <= stop_nxt_s;
      tx_r       <= tx_nxt_s;
      busy_r     <= (state_nxt_s != IDLE);
      if (accept_s) begin
        data_r    <= tx_if.p_data;
        par_en_r  <= tx_if.par_en;
        par_typ_r <= tx_if.par_typ;
        pre_r     <= tx_if.prescale;
      end else begin
        data_r    <= data_r;
        par_en_r  <= par_en_r;
        par_typ_r <= par_typ_r;
        pre_r     <= pre_r;
      end
    end
  end

  assign tx_out     = tx_r;
  assign tx_if.busy = busy_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: expected line waveform is built per frame
// as a list of bit levels from the frame format, each expanded to P cycles.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  logic rst;
  logic tx_out;
  int   checks = 0;
  int   errors = 0;
  int   n_stop;

  always #5 clk = ~clk;

  uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .tx_if  (bus),
    .tx_out (tx_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a request at a falling edge; after the accepting edge optionally scramble inputs.
  task automatic start_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                             input logic [5:0] pre, input bit hold);
    @(negedge clk);
    bus.p_data     = d;
    bus.par_en     = pen;
    bus.par_typ    = ptyp;
    bus.prescale   = pre;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.data_valid = 1'b0;
      bus.p_data     = 8'($urandom);
      bus.par_en     = 1'($urandom);
      bus.par_typ    = 1'($urandom);
      bus.prescale   = 6'($urandom);
    end
  endtask

  // Check a frame accepted at the previous rising edge. abort_at >= 0 applies reset
  // at that cycle index; inj_at >= 0 pulses data_valid with 0x3C at that cycle.
  task automatic check_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                             input int pre, input int abort_at, input int inj_at);
    logic exp_q[$];
    int   p;
    int   k;
    p = (pre == 0) ? 1 : pre;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pen) exp_q.push_back((($countones(d) % 2) == 1) ^ ptyp);
    for (int i = 0; i < n_stop; i++) exp_q.push_back(1'b1);
    k = 0;
    foreach (exp_q[b]) begin
      for (int c = 0; c < p; c++) begin
        @(negedge clk);
        if (k == abort_at) begin
          rst = 1'b1;
          @(negedge clk);
          chk("rst_tx", tx_out, 1'b1);
          chk("rst_busy", bus.busy, 1'b0);
          rst = 1'b0;
          return;
        end
        chk("tx_bit", tx_out, exp_q[b]);
        chk("busy_hi", bus.busy, 1'b1);
        if (k == inj_at) begin
          bus.data_valid = 1'b1;
          bus.p_data     = 8'h3C;
        end else if (inj_at >= 0) begin
          bus.data_valid = 1'b0;
        end
        k++;
      end
    end
    @(negedge clk);
    chk("idle_tx", tx_out, 1'b1);
    chk("idle_busy", bus.busy, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    logic       pen;
    logic       ptyp;
    logic [5:0] pre;
`ifdef UART_TX_STOP2_EN
    n_stop = 2;
`else
    n_stop = 1;
`endif
    rst            = 1'b1;
    bus.data_valid = 1'b0;
    bus.p_data     = 8'h00;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    bus.prescale   = 6'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", tx_out, 1'b1);
    chk("reset_busy", bus.busy, 1'b0);
    rst = 1'b0;

    // 0xA5 even parity, odd parity, no parity at P=8
    start_frame(8'hA5, 1'b1, 1'b0, 6'd8, 1'b0);
    check_frame(8'hA5, 1'b1, 1'b0, 8, -1, -1);
    start_frame(8'hA5, 1'b1, 1'b1, 6'd8, 1'b0);
    check_frame(8'hA5, 1'b1, 1'b1, 8, -1, -1);
    start_frame(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0);
    check_frame(8'hA5, 1'b0, 1'b0, 8, -1, -1);

    // Request with 0x3C while busy must be ignored
    start_frame(8'hA5, 1'b1, 1'b0, 6'd8, 1'b0);
    check_frame(8'hA5, 1'b1, 1'b0, 8, -1, 30);
    bus.data_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_queue_busy", bus.busy, 1'b0);
    end

    // Back-to-back with data_valid held high
    start_frame(8'h01, 1'b0, 1'b0, 6'd4, 1'b1);
    bus.p_data = 8'hFF;
    check_frame(8'h01, 1'b0, 1'b0, 4, -1, -1);
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    check_frame(8'hFF, 1'b0, 1'b0, 4, -1, -1);

    // Reset during the third data bit, then a clean frame
    d = 8'($urandom);
    start_frame(d, 1'b1, 1'b0, 6'd4, 1'b0);
    check_frame(d, 1'b1, 1'b0, 4, 4 + 8 + 1, -1);
    @(negedge clk);
    chk("post_rst_idle", tx_out, 1'b1);
    d = 8'($urandom);
    start_frame(d, 1'b1, 1'b1, 6'd4, 1'b0);
    check_frame(d, 1'b1, 1'b1, 4, -1, -1);

    // P=16 with parity, then the P=0 and P=1 corners
    d = 8'($urandom);
    start_frame(d, 1'b1, 1'b0, 6'd16, 1'b0);
    check_frame(d, 1'b1, 1'b0, 16, -1, -1);
    d = 8'($urandom);
    start_frame(d, 1'b1, 1'b1, 6'd0, 1'b0);
    check_frame(d, 1'b1, 1'b1, 0, -1, -1);
    d = 8'($urandom);
    start_frame(d, 1'b0, 1'b0, 6'd1, 1'b0);
    check_frame(d, 1'b0, 1'b0, 1, -1, -1);

    // Randomized frames
    for (int n = 0; n < 10; n++) begin
      d    = 8'($urandom);
      pen  = 1'($urandom);
      ptyp = 1'($urandom);
      pre  = 6'($urandom_range(0, 7));
      start_frame(d, pen, ptyp, pre, 1'b0);
      check_frame(d, pen, ptyp, int'(pre), -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
